// File: rtl/wb_pipe_pkg.sv
// Shared write-back select encodings for the destination-tracking pipeline.
// Values mirror def_muxs.v so the decoder and this block agree bit-for-bit.
package wb_pipe_pkg;

    localparam logic [1:0] WRREG_ALURESULT = 2'd0;
    localparam logic [1:0] WRREG_DMDATA    = 2'd1;
    localparam logic [1:0] WRREG_IMMDATA   = 2'd2;

endpackage

// File: rtl/wb_pipe_if.sv
// Bundle of ID-stage inputs, hazard controls and xREG2/3/4 outputs of wb_pipe.
// The pipe itself uses the slave view; the decode/forwarding side uses master.
interface wb_pipe_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
);
    logic          id_do_reg_write;
    logic          id_do_dm_read;
    logic [1:0]    id_select_write_reg;
    logic [AW-1:0] id_write_reg_addr;
    logic [DW-1:0] id_imm_extend;
    logic          do_hazard;
    logic          flush;
    logic          dm_wait;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] dm_read_data;

    logic          xREG2_do_reg_write;
    logic          xREG2_do_dm_read;
    logic [1:0]    xREG2_select_write_reg;
    logic [AW-1:0] xREG2_write_reg_addr;
    logic [DW-1:0] xREG2_imm_extend;
    logic          xREG3_do_reg_write;
    logic [AW-1:0] xREG3_write_reg_addr;
    logic [DW-1:0] write_reg_data;
    logic          xREG4_do_reg_write;
    logic [AW-1:0] xREG4_write_reg_addr;
    logic [DW-1:0] xREG4_write_reg_data;
    logic          hold_ifid;
    logic [CW-1:0] stall_count;

    modport slave (
        input  id_do_reg_write, id_do_dm_read, id_select_write_reg,
               id_write_reg_addr, id_imm_extend, do_hazard, flush, dm_wait,
               alu_result, dm_read_data,
        output xREG2_do_reg_write, xREG2_do_dm_read, xREG2_select_write_reg,
               xREG2_write_reg_addr, xREG2_imm_extend, xREG3_do_reg_write,
               xREG3_write_reg_addr, write_reg_data, xREG4_do_reg_write,
               xREG4_write_reg_addr, xREG4_write_reg_data, hold_ifid, stall_count
    );

    modport master (
        output id_do_reg_write, id_do_dm_read, id_select_write_reg,
               id_write_reg_addr, id_imm_extend, do_hazard, flush, dm_wait,
               alu_result, dm_read_data,
        input  xREG2_do_reg_write, xREG2_do_dm_read, xREG2_select_write_reg,
               xREG2_write_reg_addr, xREG2_imm_extend, xREG3_do_reg_write,
               xREG3_write_reg_addr, write_reg_data, xREG4_do_reg_write,
               xREG4_write_reg_addr, xREG4_write_reg_data, hold_ifid, stall_count
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline register: hold when en_i=0, and on clr_i zero the top FW bits
// (the control flags) while the rest of the word loads normally.
module pipe_stage_reg #(
    parameter int           W       = 8,
    parameter int           FW      = 0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // FW=0 yields an all-zero mask, so the clear input becomes a no-op.
    localparam logic [W-1:0] CLR_MASK = ~({W{1'b1}} >> FW);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = clr_i ? (d_i & ~CLR_MASK) : d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/wb_pipe.sv
// Destination-tracking ID/EX, EX/MEM, MEM/WB registers with load-use bubble,
// branch flush, data-memory freeze and a saturating stall counter.
module wb_pipe
    import wb_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input  logic    clock,
    input  logic    reset_n,
    wb_pipe_if.slave bus
);

    localparam int X2W = 4 + AW + DW;
    localparam int X3W = 4 + AW + DW;
    localparam int X4W = 1 + AW + DW;
    localparam logic [X2W-1:0] X2_RST = {2'b00, WRREG_ALURESULT, {AW{1'b0}}, {DW{1'b0}}};
    localparam logic [X3W-1:0] X3_RST = {2'b00, WRREG_ALURESULT, {AW{1'b0}}, {DW{1'b0}}};

    logic           advance;
    logic           bubble;
    logic [X2W-1:0] x2_d, x2_q;
    logic [X3W-1:0] x3_d, x3_q;
    logic [X4W-1:0] x4_d, x4_q;
    logic [DW-1:0]  result3;
    logic           x3_we, x3_rd;
    logic [1:0]     x3_sel;
    logic [AW-1:0]  x3_addr;
    logic [DW-1:0]  x3_res;
    logic [CW-1:0]  stall_q, stall_d;
    logic           unused_x3_sel;

    // A freeze overrides everything, including a pending bubble decision.
    assign advance = ~bus.dm_wait;
    assign bubble  = bus.do_hazard | bus.flush;

    assign x2_d = {bus.id_do_reg_write, bus.id_do_dm_read, bus.id_select_write_reg,
                   bus.id_write_reg_addr, bus.id_imm_extend};

    pipe_stage_reg #(.W(X2W), .FW(2), .RST_VAL(X2_RST)) u_xreg2 (
        .clk_i (clock), .rst_ni(reset_n), .en_i(advance), .clr_i(bubble),
        .d_i   (x2_d),  .q_o   (x2_q)
    );

    assign {bus.xREG2_do_reg_write, bus.xREG2_do_dm_read, bus.xREG2_select_write_reg,
            bus.xREG2_write_reg_addr, bus.xREG2_imm_extend} = x2_q;

    assign result3 = (bus.xREG2_select_write_reg == WRREG_IMMDATA) ? bus.xREG2_imm_extend
                                                                   : bus.alu_result;
    assign x3_d = {bus.xREG2_do_reg_write, bus.xREG2_do_dm_read, bus.xREG2_select_write_reg,
                   bus.xREG2_write_reg_addr, result3};

    pipe_stage_reg #(.W(X3W), .FW(0), .RST_VAL(X3_RST)) u_xreg3 (
        .clk_i (clock), .rst_ni(reset_n), .en_i(advance), .clr_i(1'b0),
        .d_i   (x3_d),  .q_o   (x3_q)
    );

    assign {x3_we, x3_rd, x3_sel, x3_addr, x3_res} = x3_q;
    // The load flag alone steers the MEM mux; select travels along for visibility.
    assign unused_x3_sel = ^x3_sel;

    assign bus.xREG3_do_reg_write   = x3_we;
    assign bus.xREG3_write_reg_addr = x3_addr;
    assign bus.write_reg_data       = x3_rd ? bus.dm_read_data : x3_res;

    assign x4_d = {x3_we, x3_addr, bus.write_reg_data};

    pipe_stage_reg #(.W(X4W), .FW(0), .RST_VAL('0)) u_xreg4 (
        .clk_i (clock), .rst_ni(reset_n), .en_i(advance), .clr_i(1'b0),
        .d_i   (x4_d),  .q_o   (x4_q)
    );

    assign {bus.xREG4_do_reg_write, bus.xREG4_write_reg_addr, bus.xREG4_write_reg_data} = x4_q;

    assign bus.hold_ifid = bus.do_hazard | bus.dm_wait;

    always_comb begin
        stall_d = stall_q;
        if (bus.hold_ifid && (stall_q != {CW{1'b1}})) begin
            stall_d = stall_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_wb_pipe.sv
// Randomised and directed bench for wb_pipe against a record-per-stage model.
module tb_wb_pipe;
    import wb_pipe_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    wb_pipe_if #(.DW(32), .AW(5), .CW(16)) bus ();

    wb_pipe #(.DW(32), .AW(5), .CW(16)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // One instruction as it sits in a stage; dc marks a bubble whose
    // address/data fields carry no meaning.
    typedef struct {
        logic        we;
        logic        rd;
        logic [1:0]  sel;
        logic [4:0]  addr;
        logic [31:0] val;
        bit          dc;
    } rec_t;

    rec_t        m_ex, m_mem, m_wb;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rec_t z;
        z.we = 0; z.rd = 0; z.sel = WRREG_ALURESULT; z.addr = '0; z.val = '0; z.dc = 0;
        m_ex = z; m_mem = z; m_wb = z; m_cnt = '0;
    endtask

    task automatic model_step();
        rec_t n_ex, n_mem, n_wb;
        if (!bus.dm_wait) begin
            n_wb      = m_mem;
            n_wb.val  = m_mem.rd ? bus.dm_read_data : m_mem.val;
            n_mem     = m_ex;
            n_mem.val = (m_ex.sel == WRREG_IMMDATA) ? m_ex.val : bus.alu_result;
            n_ex.we   = bus.id_do_reg_write;
            n_ex.rd   = bus.id_do_dm_read;
            n_ex.sel  = bus.id_select_write_reg;
            n_ex.addr = bus.id_write_reg_addr;
            n_ex.val  = bus.id_imm_extend;
            n_ex.dc   = 0;
            if (bus.do_hazard || bus.flush) begin
                n_ex.we = 0; n_ex.rd = 0; n_ex.dc = 1;
            end
            m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
        end
        if ((bus.do_hazard || bus.dm_wait) && m_cnt != 16'hFFFF) m_cnt++;
    endtask

    task automatic compare_all();
        check("x2_we", bus.xREG2_do_reg_write, m_ex.we);
        check("x2_rd", bus.xREG2_do_dm_read, m_ex.rd);
        if (!m_ex.dc) begin
            check("x2_sel", bus.xREG2_select_write_reg, m_ex.sel);
            check("x2_addr", bus.xREG2_write_reg_addr, m_ex.addr);
            check("x2_imm", bus.xREG2_imm_extend, m_ex.val);
        end
        check("x3_we", bus.xREG3_do_reg_write, m_mem.we);
        if (!m_mem.dc) begin
            check("x3_addr", bus.xREG3_write_reg_addr, m_mem.addr);
            check("wrd", bus.write_reg_data, m_mem.rd ? bus.dm_read_data : m_mem.val);
        end
        check("x4_we", bus.xREG4_do_reg_write, m_wb.we);
        if (!m_wb.dc) begin
            check("x4_addr", bus.xREG4_write_reg_addr, m_wb.addr);
            check("x4_data", bus.xREG4_write_reg_data, m_wb.val);
        end
        check("hold", bus.hold_ifid, bus.do_hazard | bus.dm_wait);
        check("stall", bus.stall_count, m_cnt);
    endtask

    task automatic set_in(input logic we, input logic rd, input logic [1:0] sel,
                          input logic [4:0] addr, input logic [31:0] imm, input logic haz,
                          input logic fl, input logic dw, input logic [31:0] alu,
                          input logic [31:0] dm);
        bus.id_do_reg_write = we;  bus.id_do_dm_read = rd;  bus.id_select_write_reg = sel;
        bus.id_write_reg_addr = addr;  bus.id_imm_extend = imm;  bus.do_hazard = haz;
        bus.flush = fl;  bus.dm_wait = dw;  bus.alu_result = alu;  bus.dm_read_data = dm;
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick();
        #1 compare_all();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    initial begin
        logic       r_rd;
        logic [1:0] r_sel;

        set_in(0, 0, WRREG_ALURESULT, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_x2_sel", bus.xREG2_select_write_reg, WRREG_ALURESULT);
        check("rst_x4_data", bus.xREG4_write_reg_data, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back ALU op to r3
        set_in(1, 0, WRREG_ALURESULT, 3, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, WRREG_ALURESULT, 0, 0, 0, 0, 0, 32'h11, 0);
        tick();
        check("b2b_x3_addr", bus.xREG3_write_reg_addr, 5'd3);
        check("b2b_wrd", bus.write_reg_data, 32'h11);
        tick();
        check("b2b_x4_data", bus.xREG4_write_reg_data, 32'h11);
        check("b2b_x4_we", bus.xREG4_do_reg_write, 1'b1);

        // Immediate op: ALU output must be ignored
        set_in(1, 0, WRREG_IMMDATA, 7, 32'hFFFF_FFF0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, WRREG_ALURESULT, 0, 0, 0, 0, 0, 32'h1234, 0);
        tick();
        check("imm_wrd", bus.write_reg_data, 32'hFFFF_FFF0);

        // Load-use on r5
        set_in(1, 1, WRREG_DMDATA, 5, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 0, WRREG_ALURESULT, 6, 0, 1, 0, 0, 0, 32'hCAFE);
        #1 check("lu_hold", bus.hold_ifid, 1'b1);
        tick();
        check("lu_x2_we", bus.xREG2_do_reg_write, 1'b0);
        check("lu_stall", bus.stall_count, 16'd1);
        check("lu_wrd", bus.write_reg_data, 32'hCAFE);
        set_in(1, 0, WRREG_ALURESULT, 6, 0, 0, 0, 0, 0, 32'hCAFE);
        tick();
        check("lu_x4_data", bus.xREG4_write_reg_data, 32'hCAFE);
        check("lu_x4_addr", bus.xREG4_write_reg_addr, 5'd5);

        // Flush of a writing load in ID
        set_in(1, 1, WRREG_DMDATA, 8, 0, 0, 1, 0, 0, 0);
        #1 check("fl_hold", bus.hold_ifid, 1'b0);
        tick();
        check("fl_x2_we", bus.xREG2_do_reg_write, 1'b0);
        check("fl_x2_rd", bus.xREG2_do_dm_read, 1'b0);

        // Three-cycle freeze with flush pending
        set_in(1, 0, WRREG_ALURESULT, 9, 0, 0, 0, 0, 32'h99, 0);
        tick();
        set_in(1, 0, WRREG_ALURESULT, 10, 0, 0, 1, 1, 32'h55, 0);
        repeat (3) tick();
        check("fz_x2_we", bus.xREG2_do_reg_write, 1'b1);
        check("fz_x2_addr", bus.xREG2_write_reg_addr, 5'd9);
        check("fz_stall", bus.stall_count, 16'd4);
        bus.dm_wait = 1'b0;
        tick();
        check("fz_bubble", bus.xREG2_do_reg_write, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r_rd  = ($urandom % 4) == 0;
            r_sel = r_rd ? WRREG_DMDATA : (($urandom % 2) ? WRREG_IMMDATA : WRREG_ALURESULT);
            set_in(1'($urandom), r_rd, r_sel, 5'($urandom), $urandom,
                   ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
                   $urandom, $urandom);
            tick();
        end

        // Async reset while a write sits in WB
        set_in(1, 0, WRREG_ALURESULT, 12, 0, 0, 0, 0, 32'h77, 0);
        repeat (3) tick();
        check("ar_x4_we_pre", bus.xREG4_do_reg_write, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        check("ar_x2_we", bus.xREG2_do_reg_write, 1'b0);
        check("ar_x2_rd", bus.xREG2_do_dm_read, 1'b0);
        check("ar_x3_we", bus.xREG3_do_reg_write, 1'b0);
        check("ar_x4_we", bus.xREG4_do_reg_write, 1'b0);
        check("ar_stall", bus.stall_count, 16'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Saturation via a long freeze
        set_in(0, 0, WRREG_ALURESULT, 0, 0, 0, 0, 1, 0, 0);
        repeat (65540) begin
            @(posedge clock);
            model_step();
        end
        @(negedge clock);
        check("sat_stall", bus.stall_count, 16'hFFFF);
        tick();
        check("sat_stall_hold", bus.stall_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
